// File: rtl/game_phase_sequencer.sv
// ---------------------------------------------------------------------------
// game_phase_sequencer
//   Central FSM for one play-through. It steps PRELIM -> GAME -> ANSWER ->
//   POST -> JUDGE and times each phase from a 1 Hz square wave. It emits a
//   one-cycle pulse on entry to each timed phase. It tracks the current level
//   and sets the symbol-generator terminal count for that level. The Judge
//   result then either advances the level or ends the game in WIN or LOSE.
//
// Optional feature macro: SEQ_PAUSE_EN (adds the `pause` input, which freezes
//   all second-based timers while it is high).
//
// Ports
//   Clk100M     in   1   system clock
//   resetN      in   1   asynchronous active-low reset
//   Clk1Hz      in   1   raw 1 Hz square wave (synchronised internally)
//   start       in   1   pulse: start a game from IDLE / WIN / LOSE
//   judgeValid  in   1   pulse: Judge result valid (used only in JUDGE)
//   judgePass   in   1   qualified by judgeValid, 1 = level passed
//   pause       in   1   (SEQ_PAUSE_EN only) freeze timers
//   phase       out  3   IDLE=0 PRELIM=1 GAME=2 ANSWER=3 POST=4 JUDGE=5 WIN=6 LOSE=7
//   prelimSig   out  1   entry pulse, PRELIM
//   gameSig     out  1   entry pulse, GAME
//   answerSig   out  1   entry pulse, ANSWER
//   postSig     out  1   entry pulse, POST
//   secLeft     out  4   whole seconds remaining in a timed phase, else 0
//   curLevel    out  4   current level, 0-based
//   symGenMax   out  32  symbol generator terminal count for curLevel
//   victory     out  1   high while in WIN
//   lose        out  1   high while in LOSE
// ---------------------------------------------------------------------------
module game_phase_sequencer #(
    parameter int unsigned PRELIM_SEC    = 3,
    parameter int unsigned GAME_SEC      = 10,
    parameter int unsigned ANSWER_SEC    = 5,
    parameter int unsigned POST_SEC      = 3,
    parameter int unsigned JUDGE_TMO_SEC = 2,
    parameter int unsigned NUM_LEVELS    = 8,
    parameter int unsigned GEN_BASE      = 100_000_000,
    parameter int unsigned GEN_STEP      = 10_000_000,
    parameter int unsigned GEN_MIN       = 20_000_000
) (
    input  logic        Clk100M,
    input  logic        resetN,
    input  logic        Clk1Hz,
    input  logic        start,
    input  logic        judgeValid,
    input  logic        judgePass,
`ifdef SEQ_PAUSE_EN
    input  logic        pause,
`endif
    output logic [2:0]  phase,
    output logic        prelimSig,
    output logic        gameSig,
    output logic        answerSig,
    output logic        postSig,
    output logic [3:0]  secLeft,
    output logic [3:0]  curLevel,
    output logic [31:0] symGenMax,
    output logic        victory,
    output logic        lose
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRELIM = 3'd1,
        S_GAME   = 3'd2,
        S_ANSWER = 3'd3,
        S_POST   = 3'd4,
        S_JUDGE  = 3'd5,
        S_WIN    = 3'd6,
        S_LOSE   = 3'd7
    } state_t;

    localparam logic [3:0] PRELIM_L = 4'(PRELIM_SEC);
    localparam logic [3:0] GAME_L   = 4'(GAME_SEC);
    localparam logic [3:0] ANSWER_L = 4'(ANSWER_SEC);
    localparam logic [3:0] POST_L   = 4'(POST_SEC);
    localparam logic [3:0] TMO_L    = 4'(JUDGE_TMO_SEC);
    localparam logic [3:0] LAST_LVL = 4'(NUM_LEVELS - 1);

    // Terminal count for a level: GEN_BASE - lvl*GEN_STEP, clamped at zero
    // instead of wrapping, then floored at GEN_MIN.
    function automatic logic [31:0] gen_max(input logic [3:0] lvl);
        logic [63:0] dec;
        logic [63:0] rem;
        dec = 64'(lvl) * 64'(GEN_STEP);
        rem = (dec >= 64'(GEN_BASE)) ? 64'd0 : (64'(GEN_BASE) - dec);
        if (rem < 64'(GEN_MIN)) begin
            rem = 64'(GEN_MIN);
        end
        return rem[31:0];
    endfunction

    // 1 Hz synchroniser and rising-edge detect. The FSM consumes the tick on
    // the third clock edge after the raw rising edge.
    logic sync1_q, sync2_q, sync3_q;
    logic sec_tick, tick_en;

    always_ff @(posedge Clk100M or negedge resetN) begin
        if (!resetN) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= Clk1Hz;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign sec_tick = sync2_q & ~sync3_q;

`ifdef SEQ_PAUSE_EN
    assign tick_en = sec_tick & ~pause;
`else
    assign tick_en = sec_tick;
`endif

    state_t      state_q;
    logic        prelim_q, game_q, answer_q, post_q;
    logic        victory_q, lose_q;
    logic [3:0]  sec_q, tmo_q, level_q;
    logic [31:0] sym_q;

    always_ff @(posedge Clk100M or negedge resetN) begin
        if (!resetN) begin
            state_q   <= S_IDLE;
            prelim_q  <= 1'b0;
            game_q    <= 1'b0;
            answer_q  <= 1'b0;
            post_q    <= 1'b0;
            victory_q <= 1'b0;
            lose_q    <= 1'b0;
            sec_q     <= 4'd0;
            tmo_q     <= 4'd0;
            level_q   <= 4'd0;
            sym_q     <= GEN_BASE;
        end else begin
            // Entry pulses are high for exactly one cycle.
            prelim_q <= 1'b0;
            game_q   <= 1'b0;
            answer_q <= 1'b0;
            post_q   <= 1'b0;
            // Follows level_q with one cycle of delay.
            sym_q    <= gen_max(level_q);

            case (state_q)
                S_IDLE, S_WIN, S_LOSE: begin
                    if (start) begin
                        state_q   <= S_PRELIM;
                        sec_q     <= PRELIM_L;
                        prelim_q  <= 1'b1;
                        level_q   <= 4'd0;
                        victory_q <= 1'b0;
                        lose_q    <= 1'b0;
                    end
                end
                S_PRELIM: begin
                    if (tick_en) begin
                        if (sec_q == 4'd1) begin
                            state_q <= S_GAME;
                            sec_q   <= GAME_L;
                            game_q  <= 1'b1;
                        end else begin
                            sec_q <= sec_q - 4'd1;
                        end
                    end
                end
                S_GAME: begin
                    if (tick_en) begin
                        if (sec_q == 4'd1) begin
                            state_q  <= S_ANSWER;
                            sec_q    <= ANSWER_L;
                            answer_q <= 1'b1;
                        end else begin
                            sec_q <= sec_q - 4'd1;
                        end
                    end
                end
                S_ANSWER: begin
                    if (tick_en) begin
                        if (sec_q == 4'd1) begin
                            state_q <= S_POST;
                            sec_q   <= POST_L;
                            post_q  <= 1'b1;
                        end else begin
                            sec_q <= sec_q - 4'd1;
                        end
                    end
                end
                S_POST: begin
                    if (tick_en) begin
                        if (sec_q == 4'd1) begin
                            state_q <= S_JUDGE;
                            sec_q   <= 4'd0;
                            tmo_q   <= TMO_L;
                        end else begin
                            sec_q <= sec_q - 4'd1;
                        end
                    end
                end
                S_JUDGE: begin
                    // A Judge result wins over a timeout expiring on the same edge.
                    if (judgeValid) begin
                        if (!judgePass) begin
                            state_q <= S_LOSE;
                            lose_q  <= 1'b1;
                        end else if (level_q == LAST_LVL) begin
                            state_q   <= S_WIN;
                            victory_q <= 1'b1;
                        end else begin
                            state_q  <= S_PRELIM;
                            sec_q    <= PRELIM_L;
                            prelim_q <= 1'b1;
                            level_q  <= level_q + 4'd1;
                        end
                    end else if (tick_en) begin
                        if (tmo_q == 4'd1) begin
                            state_q <= S_LOSE;
                            lose_q  <= 1'b1;
                        end else begin
                            tmo_q <= tmo_q - 4'd1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    sec_q   <= 4'd0;
                end
            endcase
        end
    end

    assign phase     = state_q;
    assign prelimSig = prelim_q;
    assign gameSig   = game_q;
    assign answerSig = answer_q;
    assign postSig   = post_q;
    assign secLeft   = sec_q;
    assign curLevel  = level_q;
    assign symGenMax = sym_q;
    assign victory   = victory_q;
    assign lose      = lose_q;

endmodule
